// File: rtl/alu_step_sequencer_if.sv
// Handshake/bus bundle for the ALU step sequencer.
// i_* drive the sequencer, o_* are its strobes, selects and status.
interface alu_step_sequencer_if #(
  parameter int IR_W      = 32,
  parameter int REG_COUNT = 16,
  parameter int OPW       = 5
);
  logic                 i_run;
  logic [IR_W-1:0]      i_ir;
  logic                 i_mem_ready;
  logic                 o_pc_out;
  logic                 o_mar_in;
  logic                 o_inc_pc;
  logic                 o_z_in;
  logic                 o_zlow_out;
  logic                 o_zhigh_out;
  logic                 o_pc_in;
  logic                 o_read;
  logic                 o_mdr_in;
  logic                 o_mdr_out;
  logic                 o_ir_in;
  logic                 o_y_in;
  logic                 o_hi_in;
  logic                 o_lo_in;
  logic [REG_COUNT-1:0] o_rout_sel;
  logic [REG_COUNT-1:0] o_rin_sel;
  logic [OPW-1:0]       o_alu_op;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_illegal_op;
  logic [15:0]          o_instr_count;

  modport master (
    output i_run, i_ir, i_mem_ready,
    input  o_pc_out, o_mar_in, o_inc_pc, o_z_in,
    input  o_zlow_out, o_zhigh_out, o_pc_in, o_read,
    input  o_mdr_in, o_mdr_out, o_ir_in, o_y_in,
    input  o_hi_in, o_lo_in, o_rout_sel, o_rin_sel,
    input  o_alu_op, o_busy, o_done, o_illegal_op,
    input  o_instr_count
  );

  modport slave (
    input  i_run, i_ir, i_mem_ready,
    output o_pc_out, o_mar_in, o_inc_pc, o_z_in,
    output o_zlow_out, o_zhigh_out, o_pc_in, o_read,
    output o_mdr_in, o_mdr_out, o_ir_in, o_y_in,
    output o_hi_in, o_lo_in, o_rout_sel, o_rin_sel,
    output o_alu_op, o_busy, o_done, o_illegal_op,
    output o_instr_count
  );
endinterface

// File: rtl/alu_step_sequencer.sv
// Multi-cycle control sequencer: fetch (T0-T2), decode/execute (T3-T6).
// Ports: i_clk, i_rst (sync, active high), bus (slave side of the _if).
module alu_step_sequencer #(
  parameter int IR_W      = 32,
  parameter int REG_COUNT = 16,
  parameter int OPW       = 5
) (
  input logic                  i_clk,
  input logic                  i_rst,
  alu_step_sequencer_if.slave  bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T1W, S_T2,
    S_T3, S_T4, S_T5, S_T6
  } state_t;

  state_t      r_state;
  logic [15:0] r_count;

  logic [4:0]  w_op;
  logic [3:0]  w_ra;
  logic [3:0]  w_rb;
  logic [3:0]  w_rc;
  logic        w_op_ok;
  logic        w_muldiv;
  logic        w_legal;
  logic        w_done;
  logic        w_unused_ir;

  assign w_op = bus.i_ir[31:27];
  assign w_ra = bus.i_ir[26:23];
  assign w_rb = bus.i_ir[22:19];
  assign w_rc = bus.i_ir[18:15];
  assign w_unused_ir = ^bus.i_ir;

  function automatic logic f_reg_ok(input logic [3:0] r);
    return {1'b0, r} < 5'(REG_COUNT);
  endfunction

  always_comb begin
    w_op_ok = 1'b0;
    case (w_op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
      5'd9, 5'd10, 5'd11, 5'd15, 5'd16:
        w_op_ok = 1'b1;
      default: w_op_ok = 1'b0;
    endcase
  end

  // MUL/DIV write HI/LO instead of Ra, so Ra is not range-checked.
  assign w_muldiv = (w_op == 5'd15) || (w_op == 5'd16);
  assign w_legal  = w_op_ok && f_reg_ok(w_rb) && f_reg_ok(w_rc)
                 && (w_muldiv || f_reg_ok(w_ra));
  assign w_done   = (r_state == S_T6)
                 || ((r_state == S_T5) && !w_muldiv);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      if (w_done) r_count <= r_count + 16'd1;
      unique case (r_state)
        S_IDLE: r_state <= bus.i_run ? S_T0 : S_IDLE;
        S_T0:   r_state <= S_T1;
        S_T1:   r_state <= bus.i_mem_ready ? S_T2 : S_T1W;
        S_T1W:  r_state <= bus.i_mem_ready ? S_T2 : S_T1W;
        S_T2:   r_state <= S_T3;
        S_T3:   r_state <= w_legal ? S_T4 : S_IDLE;
        S_T4:   r_state <= S_T5;
        S_T5: begin
          if (w_muldiv)       r_state <= S_T6;
          else if (bus.i_run) r_state <= S_T0;
          else                r_state <= S_IDLE;
        end
        S_T6:   r_state <= bus.i_run ? S_T0 : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.o_pc_out     = 1'b0;
    bus.o_mar_in     = 1'b0;
    bus.o_inc_pc     = 1'b0;
    bus.o_z_in       = 1'b0;
    bus.o_zlow_out   = 1'b0;
    bus.o_zhigh_out  = 1'b0;
    bus.o_pc_in      = 1'b0;
    bus.o_read       = 1'b0;
    bus.o_mdr_in     = 1'b0;
    bus.o_mdr_out    = 1'b0;
    bus.o_ir_in      = 1'b0;
    bus.o_y_in       = 1'b0;
    bus.o_hi_in      = 1'b0;
    bus.o_lo_in      = 1'b0;
    bus.o_rout_sel   = '0;
    bus.o_rin_sel    = '0;
    bus.o_alu_op     = '0;
    bus.o_illegal_op = 1'b0;
    bus.o_busy       = (r_state != S_IDLE);
    bus.o_done       = w_done;
    bus.o_instr_count = r_count;
    case (r_state)
      S_T0: begin
        bus.o_pc_out = 1'b1;
        bus.o_mar_in = 1'b1;
        bus.o_inc_pc = 1'b1;
        bus.o_z_in   = 1'b1;
      end
      S_T1: begin
        bus.o_zlow_out = 1'b1;
        bus.o_pc_in    = 1'b1;
        bus.o_read     = 1'b1;
        bus.o_mdr_in   = 1'b1;
      end
      S_T1W: begin
        bus.o_read   = 1'b1;
        bus.o_mdr_in = 1'b1;
      end
      S_T2: begin
        bus.o_mdr_out = 1'b1;
        bus.o_ir_in   = 1'b1;
      end
      S_T3: begin
        if (w_legal) begin
          bus.o_rout_sel = REG_COUNT'(1) << w_rb;
          bus.o_y_in     = 1'b1;
        end else begin
          bus.o_illegal_op = 1'b1;
        end
      end
      S_T4: begin
        bus.o_rout_sel = REG_COUNT'(1) << w_rc;
        bus.o_z_in     = 1'b1;
        bus.o_alu_op   = OPW'(w_op);
      end
      S_T5: begin
        bus.o_zlow_out = 1'b1;
        if (w_muldiv) bus.o_lo_in = 1'b1;
        else bus.o_rin_sel = REG_COUNT'(1) << w_ra;
      end
      S_T6: begin
        bus.o_zhigh_out = 1'b1;
        bus.o_hi_in     = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_alu_step_sequencer.sv
// Randomized bench for alu_step_sequencer against a step-list model.
// Second instance with REG_COUNT=8 covers register range rejection.
module tb_alu_step_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_step_sequencer_if #(.IR_W(32), .REG_COUNT(16), .OPW(5)) bus ();
  alu_step_sequencer_if #(.IR_W(32), .REG_COUNT(8),  .OPW(5)) b8 ();

  alu_step_sequencer #(.IR_W(32), .REG_COUNT(16), .OPW(5)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );
  alu_step_sequencer #(.IR_W(32), .REG_COUNT(8), .OPW(5)) dut8 (
    .i_clk(clk), .i_rst(rst), .bus(b8)
  );

  typedef struct packed {
    logic pc_out, mar_in, inc_pc, z_in, zlow_out, zhigh_out, pc_in;
    logic read, mdr_in, mdr_out, ir_in, y_in, hi_in, lo_in;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [4:0]  alu;
    logic busy, done, illegal;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    obs_t o;
    bit   is_mem;
    bit   is_final;
  } step_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] model_cnt = '0;
  step_t       steps[$];
  logic [4:0]  legal_ops [11] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
    5'd8, 5'd9, 5'd10, 5'd11, 5'd15, 5'd16};

  task automatic check(input string tag, input logic [69:0] got,
                       input logic [69:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.pc_out = bus.o_pc_out;     o.mar_in = bus.o_mar_in;
    o.inc_pc = bus.o_inc_pc;     o.z_in = bus.o_z_in;
    o.zlow_out = bus.o_zlow_out; o.zhigh_out = bus.o_zhigh_out;
    o.pc_in = bus.o_pc_in;       o.read = bus.o_read;
    o.mdr_in = bus.o_mdr_in;     o.mdr_out = bus.o_mdr_out;
    o.ir_in = bus.o_ir_in;       o.y_in = bus.o_y_in;
    o.hi_in = bus.o_hi_in;       o.lo_in = bus.o_lo_in;
    o.rout = bus.o_rout_sel;     o.rin = bus.o_rin_sel;
    o.alu = bus.o_alu_op;        o.busy = bus.o_busy;
    o.done = bus.o_done;         o.illegal = bus.o_illegal_op;
    o.cnt = bus.o_instr_count;
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o = '0;
    o.cnt = model_cnt;
    return o;
  endfunction

  function automatic bit is_legal(input logic [31:0] ir, input int rc);
    bit op_ok = 0;
    bit md = (ir[31:27] == 5'd15) || (ir[31:27] == 5'd16);
    foreach (legal_ops[k]) if (legal_ops[k] == ir[31:27]) op_ok = 1;
    return op_ok && (int'(ir[22:19]) < rc) && (int'(ir[18:15]) < rc)
        && (md || int'(ir[26:23]) < rc);
  endfunction

  // Expected per-cycle outputs of one instruction, built from the step rules.
  function automatic void plan(input logic [31:0] ir, input int stall);
    obs_t b, o;
    bit md = (ir[31:27] == 5'd15) || (ir[31:27] == 5'd16);
    steps.delete();
    b = '0; b.busy = 1; b.cnt = model_cnt;
    o = b; o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.z_in = 1;
    steps.push_back('{o, 1'b0, 1'b0});
    o = b; o.zlow_out = 1; o.pc_in = 1; o.read = 1; o.mdr_in = 1;
    steps.push_back('{o, 1'b1, 1'b0});
    for (int k = 0; k < stall; k++) begin
      o = b; o.read = 1; o.mdr_in = 1;
      steps.push_back('{o, 1'b1, 1'b0});
    end
    o = b; o.mdr_out = 1; o.ir_in = 1;
    steps.push_back('{o, 1'b0, 1'b0});
    if (!is_legal(ir, 16)) begin
      o = b; o.illegal = 1;
      steps.push_back('{o, 1'b0, 1'b1});
      return;
    end
    o = b; o.rout = 16'd1 << ir[22:19]; o.y_in = 1;
    steps.push_back('{o, 1'b0, 1'b0});
    o = b; o.rout = 16'd1 << ir[18:15]; o.z_in = 1; o.alu = ir[31:27];
    steps.push_back('{o, 1'b0, 1'b0});
    if (md) begin
      o = b; o.zlow_out = 1; o.lo_in = 1;
      steps.push_back('{o, 1'b0, 1'b0});
      o = b; o.zhigh_out = 1; o.hi_in = 1; o.done = 1;
      steps.push_back('{o, 1'b0, 1'b1});
    end else begin
      o = b; o.zlow_out = 1; o.rin = 16'd1 << ir[26:23]; o.done = 1;
      steps.push_back('{o, 1'b0, 1'b1});
    end
  endfunction

  // from_idle: sequencer sits in IDLE; otherwise it is about to enter T0.
  task automatic exec(input logic [31:0] ir, input int stall,
                      input bit from_idle, input bit run_after,
                      input int rst_at, output bit lg);
    int left = stall;
    lg = is_legal(ir, 16);
    if (from_idle) begin
      @(negedge clk);
      check("idle", sample(), idle_obs());
      bus.i_run = 1'b1;
      bus.i_mem_ready = 1'($urandom);
      bus.i_ir = $urandom;
    end
    plan(ir, stall);
    foreach (steps[i]) begin
      @(negedge clk);
      if (i == 0) bus.i_ir = ir;
      check($sformatf("step%0d_op%0d", i, ir[31:27]), sample(), steps[i].o);
      if (i == rst_at) begin
        rst = 1'b1;
        bus.i_run = 1'b1;
        bus.i_mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_run = 1'b0;
        model_cnt = '0;
        check("post_rst", sample(), idle_obs());
        lg = 1'b0;
        return;
      end
      if (steps[i].is_final && lg) bus.i_run = run_after;
      else bus.i_run = 1'($urandom);
      if (steps[i].is_mem) begin
        if (left == 0) bus.i_mem_ready = 1'b1;
        else begin
          bus.i_mem_ready = 1'b0;
          left--;
        end
      end else begin
        bus.i_mem_ready = 1'($urandom);
      end
    end
    if (lg) model_cnt = model_cnt + 16'd1;
  endtask

  task automatic run8(input logic [31:0] ir, input bit exp_ill,
                      input logic [7:0] exp_rout);
    @(negedge clk);
    b8.i_run = 1'b1; b8.i_mem_ready = 1'b1; b8.i_ir = ir;
    @(negedge clk);
    b8.i_run = 1'b0;
    repeat (3) @(negedge clk);
    check("r8_illegal", 70'(b8.o_illegal_op), 70'(exp_ill));
    check("r8_rout", 70'(b8.o_rout_sel), 70'(exp_rout));
    repeat (4) @(negedge clk);
    check("r8_idle", 70'(b8.o_busy), 70'd0);
  endtask

  localparam logic [31:0] AND_IR = 32'h2891_8000;

  initial begin
    bit         lg;
    bit         ch;
    bit         ra;
    int         st;
    logic [31:0] rir;
    rst = 1'b1;
    bus.i_run = 1'b0; bus.i_mem_ready = 1'b0; bus.i_ir = '0;
    b8.i_run = 1'b0;  b8.i_mem_ready = 1'b0;  b8.i_ir = '0;
    repeat (3) @(posedge clk);
    bus.i_run = 1'b1;
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    check("reset", sample(), idle_obs());
    rst = 1'b0;
    bus.i_run = 1'b0;

    exec(AND_IR, 0, 1, 0, -1, lg);
    exec(AND_IR, 3, 1, 0, -1, lg);
    exec(32'h7811_8000, 1, 1, 0, -1, lg);
    exec(32'hF800_0000, 0, 1, 0, -1, lg);
    exec(AND_IR, 0, 1, 1, -1, lg);
    exec(AND_IR, 0, 0, 0, -1, lg);
    exec(AND_IR, 0, 1, 0, 4, lg);
    exec(AND_IR, 2, 1, 0, 2, lg);
    exec(32'h8000_0000, 0, 1, 1, -1, lg);
    exec(AND_IR, 0, 0, 0, -1, lg);

    ch = 1'b0;
    repeat (150) begin
      rir = $urandom;
      if (($urandom % 4) != 0) rir[31:27] = legal_ops[$urandom % 11];
      st = int'($urandom % 4);
      ra = 1'($urandom);
      exec(rir, st, !ch, ra, -1, lg);
      ch = lg && ra;
    end
    if (ch) exec(AND_IR, 0, 0, 0, -1, lg);
    @(negedge clk);
    check("final_idle", sample(), idle_obs());

    run8({5'd3, 4'd9, 4'd1, 4'd2, 15'd0}, 1'b1, 8'h00);
    run8({5'd3, 4'd1, 4'd1, 4'd8, 15'd0}, 1'b1, 8'h00);
    run8({5'd15, 4'd9, 4'd1, 4'd2, 15'd0}, 1'b0, 8'h02);
    run8({5'd3, 4'd7, 4'd7, 4'd0, 15'd0}, 1'b0, 8'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
